// File: rtl/flywheel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flywheel_pkg : shared types and encodings for the flywheel mode sequencer
// Revision     : 1.0
// ---------------------------------------------------------------------------
package flywheel_pkg;

  localparam int DUTY_W = 12;

  localparam logic [1:0] MODE_PWM   = 2'b00;
  localparam logic [1:0] MODE_BUCK  = 2'b01;
  localparam logic [1:0] MODE_BRAKE = 2'b10;
  localparam logic [1:0] MODE_STOP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEAD  = 3'd1,
    ST_APPLY = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  function automatic logic [DUTY_W-1:0] duty_clamp(input logic [DUTY_W-1:0] duty,
                                                  input logic [DUTY_W-1:0] lim);
    return (duty > lim) ? lim : duty;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flywheel_duty_slew.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flywheel_duty_slew : prescaled, bounded-step duty ramp toward a target
// Revision           : 1.0
// ---------------------------------------------------------------------------
module flywheel_duty_slew
  import flywheel_pkg::*;
#(
  parameter int RAMP_DIV  = 256,
  parameter int RAMP_STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DUTY_W-1:0] cur_duty,
  input  logic [DUTY_W-1:0] target,
  output logic [DUTY_W-1:0] next_duty
);

  localparam logic [15:0]       c_div_last = 16'(RAMP_DIV - 1);
  localparam logic [DUTY_W-1:0] c_step     = DUTY_W'(RAMP_STEP);

  logic [15:0]       r_presc;
  logic              w_tick;
  logic [DUTY_W-1:0] w_diff;

  assign w_tick = run && (r_presc == c_div_last);

  // Prescaler is held at zero outside RUN so every RUN entry restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  always_comb begin
    next_duty = cur_duty;
    w_diff    = '0;
    if (w_tick) begin
      if (target > cur_duty) begin
        w_diff    = target - cur_duty;
        next_duty = cur_duty + ((w_diff > c_step) ? c_step : w_diff);
      end else begin
        w_diff    = cur_duty - target;
        next_duty = cur_duty - ((w_diff > c_step) ? c_step : w_diff);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/flywheel_mode_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flywheel_mode_seq : bridge mode/direction sequencer with dead time and fault
//                     latch; FLYWHEEL_SEQ_SLEW_EN enables duty slew limiting.
// Revision          : 1.0
// ---------------------------------------------------------------------------
module flywheel_mode_seq
  import flywheel_pkg::*;
#(
  parameter int                DEAD_CYC  = 64,
  parameter logic [DUTY_W-1:0] DUTY_MAX  = 12'd4092,
  parameter int                RAMP_DIV  = 256,
  parameter int                RAMP_STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              fault,
  input  logic              fault_clr,
  output logic              oe,
  output logic [1:0]        brake_m,
  output logic              torque_dir,
  output logic [DUTY_W-1:0] ctrl_data,
  output logic              busy,
  output logic              fault_latched
);

  if (DEAD_CYC < 1 || DEAD_CYC > 65535) begin : g_bad_dead_cyc
    $error("DEAD_CYC out of range");
  end
  if (RAMP_DIV < 1 || RAMP_DIV > 65536 || RAMP_STEP < 1) begin : g_bad_ramp
    $error("RAMP_DIV/RAMP_STEP out of range");
  end

  localparam logic [15:0] c_dead_last = 16'(DEAD_CYC - 1);

  state_t            r_state;
  logic [DUTY_W-1:0] r_target;
  logic [15:0]       r_dead_cnt;
  logic [1:0]        r_pend_mode;
  logic              r_pend_dir;

  logic              w_accept;
  logic              w_same;
  logic [DUTY_W-1:0] w_duty_clamped;
  logic [DUTY_W-1:0] w_run_duty;

  assign cmd_ready      = ((r_state == ST_IDLE) || (r_state == ST_RUN)) && !fault;
  assign w_accept       = cmd_valid && cmd_ready;
  assign w_same         = (cmd_mode == brake_m) && (cmd_dir == torque_dir);
  assign w_duty_clamped = duty_clamp(cmd_duty, DUTY_MAX);

`ifdef FLYWHEEL_SEQ_SLEW_EN
  flywheel_duty_slew #(
    .RAMP_DIV  (RAMP_DIV),
    .RAMP_STEP (RAMP_STEP)
  ) u_slew (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (r_state == ST_RUN),
    .cur_duty  (ctrl_data),
    .target    (r_target),
    .next_duty (w_run_duty)
  );
`else
  assign w_run_duty = r_target;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_target      <= '0;
      r_dead_cnt    <= '0;
      r_pend_mode   <= MODE_STOP;
      r_pend_dir    <= 1'b0;
      oe            <= 1'b0;
      brake_m       <= MODE_STOP;
      torque_dir    <= 1'b0;
      ctrl_data     <= '0;
      busy          <= 1'b0;
      fault_latched <= 1'b0;
    end else if (fault) begin
      // Fault wins over everything, including a command offered this cycle.
      r_state       <= ST_FAULT;
      r_target      <= '0;
      r_dead_cnt    <= '0;
      r_pend_mode   <= MODE_STOP;
      r_pend_dir    <= 1'b0;
      oe            <= 1'b0;
      brake_m       <= MODE_STOP;
      ctrl_data     <= '0;
      busy          <= 1'b0;
      fault_latched <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_target <= w_duty_clamped;
            if (cmd_mode != MODE_STOP) begin
              r_state     <= ST_DEAD;
              r_pend_mode <= cmd_mode;
              r_pend_dir  <= cmd_dir;
              r_dead_cnt  <= '0;
              busy        <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          ctrl_data <= w_run_duty;
          if (w_accept) begin
            r_target <= w_duty_clamped;
            if (!w_same) begin
              r_state     <= ST_DEAD;
              r_pend_mode <= cmd_mode;
              r_pend_dir  <= cmd_dir;
              r_dead_cnt  <= '0;
              oe          <= 1'b0;
              ctrl_data   <= '0;
              busy        <= 1'b1;
            end
          end
        end
        ST_DEAD: begin
          if (r_dead_cnt == c_dead_last) begin
            r_dead_cnt <= '0;
            r_state    <= ST_APPLY;
            brake_m    <= r_pend_mode;
            torque_dir <= r_pend_dir;
          end else begin
            r_dead_cnt <= r_dead_cnt + 16'd1;
          end
        end
        ST_APPLY: begin
          busy <= 1'b0;
          if (r_pend_mode == MODE_STOP) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RUN;
            oe      <= 1'b1;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            r_state       <= ST_IDLE;
            r_target      <= '0;
            fault_latched <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flywheel_mode_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_flywheel_mode_seq : directed self-checking bench for flywheel_mode_seq
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_flywheel_mode_seq;

  localparam int DEAD_CYC = 64;
`ifdef FLYWHEEL_SEQ_SLEW_EN
  localparam int RAMP_DIV  = 4;
`else
  localparam int RAMP_DIV  = 256;
`endif
  localparam int RAMP_STEP = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic        cmd_dir;
  logic [11:0] cmd_duty;
  logic        fault;
  logic        fault_clr;
  logic        oe;
  logic [1:0]  brake_m;
  logic        torque_dir;
  logic [11:0] ctrl_data;
  logic        busy;
  logic        fault_latched;

  int n_cmp = 0;
  int n_bad = 0;

  flywheel_mode_seq #(
    .DEAD_CYC  (DEAD_CYC),
    .DUTY_MAX  (12'd4092),
    .RAMP_DIV  (RAMP_DIV),
    .RAMP_STEP (RAMP_STEP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mode      (cmd_mode),
    .cmd_dir       (cmd_dir),
    .cmd_duty      (cmd_duty),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .oe            (oe),
    .brake_m       (brake_m),
    .torque_dir    (torque_dir),
    .ctrl_data     (ctrl_data),
    .busy          (busy),
    .fault_latched (fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command for one edge; returns just after that edge.
  task automatic send(input logic [1:0] m, input logic d, input logic [11:0] duty);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_dir   = d;
    cmd_duty  = duty;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Counts edges after acceptance until oe rises; samples torque_dir in the
  // last dead cycle and in the apply cycle.
  task automatic wait_oe(output int n, output logic dir_dead, output logic dir_apply);
    n = 0;
    dir_dead  = 1'bx;
    dir_apply = 1'bx;
    while (oe !== 1'b1 && n < 300) begin
      tick();
      n++;
      if (n == DEAD_CYC - 1) dir_dead  = torque_dir;
      if (n == DEAD_CYC)     dir_apply = torque_dir;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  int   n;
  logic dd, da;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    cmd_dir   = 1'b0;
    cmd_duty  = 12'd0;
    fault     = 1'b0;
    fault_clr = 1'b0;
    repeat (3) tick();

    check("rst_oe", oe, 0);
    check("rst_brake_m", brake_m, 3);
    check("rst_dir", torque_dir, 0);
    check("rst_ctrl", ctrl_data, 0);
    check("rst_busy", busy, 0);
    check("rst_fault_latched", fault_latched, 0);
    check("rst_ready", cmd_ready, 1);

    rst_n = 1'b1;
    tick();

    // First command from IDLE: oe visible DEAD_CYC+2 cycles counting the accept cycle.
    send(2'b00, 1'b1, 12'd1000);
    check("dead_busy", busy, 1);
    wait_oe(n, dd, da);
    check("oe_latency", n + 1, DEAD_CYC + 2);
    check("first_dir_in_dead", dd, 0);
    check("first_dir_in_apply", da, 1);
    check("run_brake_m", brake_m, 0);
    check("run_dir", torque_dir, 1);
    check("run_busy", busy, 0);
    tick();
`ifndef FLYWHEEL_SEQ_SLEW_EN
    check("run_ctrl_1000", ctrl_data, 1000);
`endif

    // Same mode/dir: target update only.
    send(2'b00, 1'b1, 12'd2000);
    check("upd_oe_kept", oe, 1);
    check("upd_busy", busy, 0);
    tick();
`ifndef FLYWHEEL_SEQ_SLEW_EN
    check("upd_ctrl_2000", ctrl_data, 2000);
`endif

    // Direction change: dead interval, dir flips in apply.
    send(2'b00, 1'b0, 12'd2000);
    check("dirchg_oe_low", oe, 0);
    check("dirchg_ctrl_zero", ctrl_data, 0);
    check("dirchg_dir_held", torque_dir, 1);
    wait_oe(n, dd, da);
    check("dirchg_oe_low_cycles", n, DEAD_CYC + 1);
    check("dirchg_dir_in_dead", dd, 1);
    check("dirchg_dir_in_apply", da, 0);
    tick();
`ifndef FLYWHEEL_SEQ_SLEW_EN
    check("dirchg_ctrl", ctrl_data, 2000);
    send(2'b00, 1'b0, 12'd4095);
    tick();
    check("clamp_ctrl", ctrl_data, 4092);
`endif

    // Stop from RUN: dead interval then IDLE with mode 11.
    send(2'b11, 1'b0, 12'd0);
    wait_idle(n);
    check("stop_dead_cycles", n, DEAD_CYC + 1);
    check("stop_brake_m", brake_m, 3);
    check("stop_oe", oe, 0);
    check("stop_ctrl", ctrl_data, 0);
    check("stop_ready", cmd_ready, 1);

    // Fault during the dead count.
    send(2'b01, 1'b1, 12'd500);
    repeat (30) tick();
    check("predfault_busy", busy, 1);
    fault = 1'b1;
    tick();
    check("fault_latched", fault_latched, 1);
    check("fault_oe", oe, 0);
    check("fault_brake_m", brake_m, 3);
    check("fault_busy", busy, 0);
    check("fault_ready", cmd_ready, 0);
    fault_clr = 1'b1;
    repeat (2) tick();
    check("clr_ignored_while_fault", fault_latched, 1);
    fault = 1'b0;
    tick();
    check("fault_exit_latched", fault_latched, 0);
    check("fault_exit_ready", cmd_ready, 1);
    fault_clr = 1'b0;
    repeat (80) tick();
    check("fault_discard_oe", oe, 0);
    check("fault_discard_brake_m", brake_m, 3);

    // Command and fault on the same cycle: command must be dropped.
    cmd_valid = 1'b1;
    cmd_mode  = 2'b00;
    cmd_dir   = 1'b0;
    cmd_duty  = 12'd300;
    fault     = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("samecyc_latched", fault_latched, 1);
    fault     = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("samecyc_exit", fault_latched, 0);
    repeat (80) tick();
    check("samecyc_oe", oe, 0);
    check("samecyc_busy", busy, 0);
    check("samecyc_brake_m", brake_m, 3);

    // Reset in the middle of a dead count.
    send(2'b10, 1'b1, 12'd100);
    repeat (10) tick();
    check("middead_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_brake_m", brake_m, 3);
    check("midrst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    tick();
    repeat (80) tick();
    check("midrst_no_apply", brake_m, 3);

`ifdef FLYWHEEL_SEQ_SLEW_EN
    // Ramp 0 -> 20 in steps of 8 every 4 cycles, then down to 10.
    send(2'b00, 1'b1, 12'd20);
    wait_oe(n, dd, da);
    repeat (3) tick();
    check("slew_pre_tick", ctrl_data, 0);
    tick();
    check("slew_t4", ctrl_data, 8);
    repeat (4) tick();
    check("slew_t8", ctrl_data, 16);
    repeat (4) tick();
    check("slew_t12", ctrl_data, 20);
    send(2'b00, 1'b1, 12'd10);
    repeat (3) tick();
    check("slew_down_t16", ctrl_data, 12);
    repeat (4) tick();
    check("slew_down_t20", ctrl_data, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
